// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode fields, unit-select and logic sub-op constants for the ALU issue path
package alu_pkg;
  localparam int OPW = 4;
  localparam int UNITS = 4;
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_SHIFT = 2'b10;
  localparam logic [1:0] UNIT_CMP = 2'b11;
  localparam logic [1:0] LOP_AND = 2'b00;
  localparam logic [1:0] LOP_OR = 2'b01;
  localparam logic [1:0] LOP_XOR = 2'b10;
  localparam logic [1:0] LOP_NOR = 2'b11;
  function automatic logic [UNITS-1:0] unit_onehot(input logic [1:0] sel);
    return UNITS'(1) << sel;
  endfunction
endpackage

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer: 2-entry valid/ready register slice with registered in_ready and synchronous flush
module alu_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic mv_q, mv_d, sv_q, sv_d, rdy_q, acc, drain;
  assign acc = in_valid & rdy_q;
  assign drain = ~mv_q | out_ready;
  assign in_ready = rdy_q;
  assign out_valid = mv_q;
  assign out_data = main_q;
  // next state: main refills from skid first (FIFO order), the skid only catches input while main stalls
  always_comb begin
    main_d = drain ? (sv_q ? skid_q : in_data) : main_q;
    mv_d = ~flush & (drain ? (sv_q | acc) : 1'b1);
    skid_d = (~drain & acc) ? in_data : skid_q;
    sv_d = ~flush & ~drain & (sv_q | acc);
  end
  // state registers; in_ready is registered from the next skid occupancy so it never depends on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      mv_q <= 1'b0;
      sv_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      mv_q <= mv_d;
      sv_q <= sv_d;
      rdy_q <= ~sv_d;
    end
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered ALU issue stage with capture-time opcode decode and issue counter
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int N = 32,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_a,
  input  logic [N-1:0]      in_b,
  input  logic [OPW-1:0]    in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_a,
  output logic [N-1:0]      out_b,
  output logic [1:0]        out_subop,
  output logic [UNITS-1:0]  out_unit_en,
  output logic [CNTW-1:0]   issued_cnt
);
  localparam int W = 2 * N + 2 + UNITS;
  logic [W-1:0] pay_in, pay_out;
  logic [UNITS-1:0] en_raw;
  logic [CNTW-1:0] cnt_q, cnt_d;
  assign pay_in = {in_a, in_b, in_op[1:0], unit_onehot(in_op[3:2])};
  alu_skid_buffer #(.W(W)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(pay_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(pay_out)
  );
  assign {out_a, out_b, out_subop, en_raw} = pay_out;
  assign out_unit_en = en_raw & {UNITS{out_valid}};
  assign cnt_d = cnt_q + CNTW'(out_valid & out_ready);
  assign issued_cnt = cnt_q;
  // count output handshakes, including one that lands in a flush cycle; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: scoreboard bench for the ALU operand issue stage
module tb_alu_operand_stage;
  localparam int N = 32;
  localparam int CW = 4;
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0] op;
  } txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [3:0] in_op = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [N-1:0] out_a, out_b;
  logic [1:0] out_subop;
  logic [3:0] out_unit_en;
  logic [CW-1:0] issued_cnt;
  txn_t q[$];
  txn_t e;
  logic [3:0] e_en;
  int n_chk = 0;
  int n_fail = 0;
  logic [CW-1:0] exp_issued = '0;
  always #5 clk = ~clk;
  alu_operand_stage #(.N(N), .CNTW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_op(in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a(out_a),
    .out_b(out_b),
    .out_subop(out_subop),
    .out_unit_en(out_unit_en),
    .issued_cnt(issued_cnt)
  );
  // scoreboard: pop and compare on output handshake, push on accept, drop everything on flush
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got a=%h b=%h but nothing expected", out_a, out_b);
        end else begin
          e = q.pop_front();
          e_en = 4'b0001 << e.op[3:2];
          if ({out_a, out_b, out_subop, out_unit_en} !== {e.a, e.b, e.op[1:0], e_en}) begin
            n_fail++;
            $display("FAIL sb_data: got a=%h b=%h sub=%b en=%b, want a=%h b=%h sub=%b en=%b",
                     out_a, out_b, out_subop, out_unit_en, e.a, e.b, e.op[1:0], e_en);
          end
        end
      end
      if (!out_valid) begin
        n_chk++;
        if (out_unit_en !== 4'b0) begin
          n_fail++;
          $display("FAIL en_idle: got %b want 0000", out_unit_en);
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{in_a, in_b, in_op});
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic rnd();
    in_a = $urandom;
    in_b = $urandom;
    in_op = 4'($urandom);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    rnd();
    q.delete();
    repeat (2) cyc();
    n_chk += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    if (issued_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", issued_cnt); end
    if (out_a !== '0) begin n_fail++; $display("FAIL rst_a: got %h want 0", out_a); end
    if (out_unit_en !== 4'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", out_unit_en); end
    in_a = 32'hF0F0_0000;
    in_b = 32'h0FF0_0000;
    in_op = 4'b0110;
    rst_n = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_chk += 4;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", out_valid); end
    if (out_unit_en !== 4'b0010) begin n_fail++; $display("FAIL first_en: got %b want 0010", out_unit_en); end
    if (out_subop !== 2'b10) begin n_fail++; $display("FAIL first_subop: got %b want 10", out_subop); end
    if (out_a !== 32'hF0F0_0000) begin n_fail++; $display("FAIL first_a: got %h want f0f00000", out_a); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    exp_issued = 1;
    cyc();
    n_chk++;
    if (issued_cnt !== exp_issued) begin n_fail++; $display("FAIL first_cnt: got %0d want %0d", issued_cnt, exp_issued); end
  endtask
  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      rnd();
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      cyc();
      n_chk++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
    end
    in_valid = 1'b0;
    repeat (2) cyc();
    out_ready = 1'b0;
    exp_issued += 8;
    n_chk += 2;
    if (issued_cnt !== exp_issued) begin n_fail++; $display("FAIL stream_cnt: got %0d want %0d", issued_cnt, exp_issued); end
    if (q.size() != 0) begin n_fail++; $display("FAIL stream_drain: got %0d left want 0", q.size()); end
  endtask
  task automatic test_backpressure();
    int acc_n = 0;
    logic acc;
    logic [N-1:0] first_a;
    out_ready = 1'b0;
    in_valid = 1'b1;
    rnd();
    first_a = in_a;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (in_ready !== (i < 2)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, in_ready, i < 2); end
      acc = in_ready;
      cyc();
      if (acc) begin acc_n++; rnd(); end
      n_chk++;
      if (out_a !== first_a) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", i, out_a, first_a); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      acc = in_ready;
      cyc();
      if (acc) begin acc_n++; rnd(); end
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    out_ready = 1'b0;
    exp_issued += CW'(acc_n);
    n_chk += 2;
    if (issued_cnt !== exp_issued) begin n_fail++; $display("FAIL bp_cnt: got %0d want %0d", issued_cnt, exp_issued); end
    if (q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d left want 0", q.size()); end
  endtask
  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    rnd();
    cyc();
    rnd();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    n_chk += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    rnd();
    cyc();
    rnd();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one_valid: got %b want 0", out_valid); end
    in_valid = 1'b1;
    in_a = 32'hCAFE_0001;
    in_b = 32'h1234_5678;
    in_op = 4'hD;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_chk += 2;
    if (out_a !== 32'hCAFE_0001) begin n_fail++; $display("FAIL flush_next_a: got %h want cafe0001", out_a); end
    if (out_unit_en !== 4'b1000) begin n_fail++; $display("FAIL flush_next_en: got %b want 1000", out_unit_en); end
    cyc();
    out_ready = 1'b0;
    exp_issued += 1;
    n_chk++;
    if (issued_cnt !== exp_issued) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", issued_cnt, exp_issued); end
  endtask
  task automatic test_wrap();
    rst_n = 1'b0;
    cyc();
    q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rnd();
      cyc();
    end
    in_valid = 1'b0;
    repeat (2) cyc();
    out_ready = 1'b0;
    exp_issued = 1;
    n_chk++;
    if (issued_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 1", issued_cnt); end
  endtask
  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    rnd();
    cyc();
    rnd();
    cyc();
    in_valid = 1'b0;
    n_chk += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ar_pre_ready: got %b want 0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    if (out_unit_en !== 4'b0) begin n_fail++; $display("FAIL ar_en: got %b want 0", out_unit_en); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b want 1", in_ready); end
    if (issued_cnt !== '0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", issued_cnt); end
    q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_post_valid: got %b want 0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
